seq_mul_add: RTL and testbench
==============================

Name: seq_mul_add

Overview:
- Sequential shift-and-add multiply-accumulate unit. Computes prod = a*b + c on unsigned W-bit operands, one multiplier bit per clock.
- It is the inverse datapath of the team's sequential restoring divider. Given the divider's quotient, divisor and remainder, it reconstructs the dividend, which serves as a self-check path and general multiply resource.
- It uses the same start / ready / done_tick handshake as the divider, so both can share one FSMD controller wrapper.

Parameters:
- W, 8, operand width in bits (W >= 2).
- CBIT, 4, iteration-counter width; equals log2(W)+1 and must hold the value W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; accepted only while ready=1.
- a  input  W  multiplicand (e.g. divisor); sampled only on the accepting edge.
- b  input  W  multiplier (e.g. quotient); sampled only on the accepting edge.
- c  input  W  addend (e.g. remainder); sampled only on the accepting edge.
- ready  output  1  high exactly when the FSM is in idle (unregistered decode of state).
- done_tick  output  1  one-cycle pulse while the FSM is in done (unregistered decode of state).
- prod  output  2W  result a*b + c; held stable from the done state until the next accepted start.

Behaviour:
- Registers:
  - state (idle / op / done).
  - a_reg, 2W bits: shifting multiplicand.
  - b_reg, W bits: shifting multiplier.
  - p_reg, 2W bits: accumulator, driven onto prod.
  - n_reg, CBIT bits: iteration counter.
- Reset (asynchronous, any time, including mid-operation): state=idle, a_reg=b_reg=p_reg=n_reg=0. Outputs after reset: prod=0, ready=1, done_tick=0. An aborted operation produces no done_tick.
- In idle with start=1:
  - p_reg <= {W'b0, c}; a_reg <= {W'b0, a}; b_reg <= b; n_reg <= W; state <= op.
  - In idle with start=0, all registers hold.
- In op, each cycle:
  - If b_reg[0]=1: p_reg <= p_reg + a_reg, a 2W-bit add.
  - Always: a_reg <= a_reg << 1; b_reg <= b_reg >> 1; n_reg <= n_reg - 1.
  - When the decremented count equals 0: state <= done.
- In done: all datapath registers hold; state <= idle.
- Fixed latency, with no early termination on b=0:
  - Start is accepted at edge k; op iterations occur at edges k+1 .. k+W.
  - done_tick is high for exactly the one cycle following edge k+W.
  - ready returns high after edge k+W+1.
  - Total busy time is W+1 cycles.
- Start outside idle (op or done) is ignored and does not disturb the operation. Back-to-back starts are only possible on the first idle cycle after done.
- Operand changes after the accepting edge have no effect.
- Width rule: the maximum result (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W fits in 2W bits, so no overflow is possible and there is no carry-out port.
- prod reflects p_reg continuously. Its intermediate values during op are partial sums; prod is valid only from the done cycle onward.
- The default state branch recovers to idle.

Test Plan:
- W=8: a=11, b=13, c=5, start pulse -> done_tick exactly 9 cycles after the accepting edge; prod=0x0094 (148); ready low for 9 cycles.
- a=0xFF, b=0xFF, c=0xFF -> prod=0xFF00; a=0, b=0, c=0 -> prod=0x0000, with the same fixed latency; a=0x07, b=0x00, c=0x2A -> prod=0x002A.
- Divider round-trip: for a sweep of dividend/divisor pairs (divisor != 0), feed a=divisor, b=quotient, c=remainder -> prod[7:0]=dividend and prod[15:8]=0.
- a=3, b=4, c=0 accepted; start held high and operands changed to 9/9/9 throughout op and done -> prod=12, a single done_tick; a new operation starts only on the first idle cycle.
- Reset asserted asynchronously at the 4th op cycle of a=200, b=100 -> immediately state idle, prod=0, ready=1, no done_tick; a following a=2, b=3, c=1 gives prod=7.
- Out-of-reset check: prod=0, ready=1, done_tick=0; with no start for 20 cycles, outputs stay unchanged.

Source files
------------

// File: rtl/seq_mul_add_if.sv
// seq_mul_add handshake and operand bus.
// Master drives start/operands, slave returns status and result.
interface seq_mul_add_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic           ready;
  logic           done_tick;
  logic [2*W-1:0] prod;

  modport master (
    output start, a, b, c,
    input  ready, done_tick, prod
  );

  modport slave (
    input  start, a, b, c,
    output ready, done_tick, prod
  );
endinterface

// File: rtl/seq_mul_add.sv
// Sequential shift-and-add multiply-accumulate: prod = a*b + c.
// One multiplier bit per clock, fixed W+1 cycle busy time.
module seq_mul_add #(
  parameter int W    = 8,
  parameter int CBIT = 4
) (
  input  logic clk,
  input  logic reset,
  seq_mul_add_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_t;

  state_t          state;
  logic [2*W-1:0]  a_reg;
  logic [W-1:0]    b_reg;
  logic [2*W-1:0]  p_reg;
  logic [CBIT-1:0] n_reg;
  logic [CBIT-1:0] n_next;

  assign n_next = n_reg - CBIT'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
      n_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            p_reg <= {{W{1'b0}}, bus.c};
            a_reg <= {{W{1'b0}}, bus.a};
            b_reg <= bus.b;
            n_reg <= CBIT'(W);
            state <= OP;
          end
        end
        OP: begin
          if (b_reg[0])
            p_reg <= p_reg + a_reg;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          n_reg <= n_next;
          // no early exit on b=0: latency is fixed
          if (n_next == '0)
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done_tick = (state == DONE);
  assign bus.prod      = p_reg;

endmodule

// File: tb/tb_seq_mul_add.sv
// Self-checking bench for seq_mul_add.
// Reference model: plain a*b+c integer arithmetic.
module tb_seq_mul_add;

  localparam int W = 8;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  seq_mul_add_if #(.W(W)) bus ();

  seq_mul_add #(.W(W), .CBIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(
    input int a, input int b, input int c
  );
    return (2*W)'(a * b + c);
  endfunction

  // Issue one operation; observe W+2 negedges after the accepting edge.
  task automatic do_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  bit           hold,
    output logic [2*W-1:0] p,
    output int           lat,
    output int           busy,
    output int           dones,
    output bit           ready_end
  );
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c = c;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.a = 8'd9;
      bus.b = 8'd9;
      bus.c = 8'd9;
    end else begin
      bus.start = 1'b0;
      bus.a = ~a;
      bus.b = ~b;
      bus.c = ~c;
    end
    lat = -1;
    busy = 0;
    dones = 0;
    p = '0;
    ready_end = 1'b0;
    for (int i = 0; i <= W + 1; i++) begin
      @(negedge clk);
      if (!bus.ready && i <= W) busy++;
      if (bus.done_tick) begin
        dones++;
        if (lat < 0) lat = i;
        p = bus.prod;
      end
      if (i == W + 1) ready_end = bus.ready;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.ready) begin
      errors++;
      $display("FAIL wait_idle: ready=%b required 1", bus.ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.prod !== 16'h0 || bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: prod=%h ready=%b done=%b required 0000/1/0",
               bus.prod, bus.ready, bus.done_tick);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.prod !== 16'h0 || bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: prod=%h ready=%b done=%b", i,
                 bus.prod, bus.ready, bus.done_tick);
      end
    end
  endtask

  task automatic check_op(
    input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [W-1:0] c
  );
    logic [2*W-1:0] p, exp;
    int lat, busy, dones;
    bit re;
    exp = model(int'(a), int'(b), int'(c));
    do_op(a, b, c, 1'b0, p, lat, busy, dones, re);
    checks++;
    if (p !== exp) begin
      errors++;
      $display("FAIL %s prod: got %h required %h", nm, p, exp);
    end
    checks++;
    if (lat != W || dones != 1 || busy != W + 1 || !re) begin
      errors++;
      $display("FAIL %s timing: lat=%0d dones=%0d busy=%0d ready=%b required %0d/1/%0d/1",
               nm, lat, dones, busy, re, W, W + 1);
    end
    checks++;
    if (bus.prod !== exp) begin
      errors++;
      $display("FAIL %s prod_held: got %h required %h", nm, bus.prod, exp);
    end
  endtask

  task automatic test_directed();
    check_op("basic_11_13_5", 8'd11, 8'd13, 8'd5);
    check_op("max_ff", 8'hFF, 8'hFF, 8'hFF);
    check_op("zero", 8'h00, 8'h00, 8'h00);
    check_op("b_zero", 8'h07, 8'h00, 8'h2A);
  endtask

  task automatic test_divider_roundtrip();
    logic [2*W-1:0] p;
    int lat, busy, dones;
    bit re;
    int dd, dv;
    for (int i = 0; i < 30; i++) begin
      dv = $urandom_range(1, 255);
      dd = $urandom_range(0, 255);
      do_op(W'(dv), W'(dd / dv), W'(dd % dv), 1'b0, p, lat, busy, dones, re);
      checks++;
      if (p[7:0] !== dd[7:0] || p[15:8] !== 8'h0 || lat != W) begin
        errors++;
        $display("FAIL roundtrip dd=%0d dv=%0d: prod=%h lat=%0d required %h lat %0d",
                 dd, dv, p, lat, dd[15:0], W);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, c;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = W'($urandom);
      check_op("random", a, b, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] p;
    int lat, busy, dones;
    bit re;
    do_op(8'd3, 8'd4, 8'd0, 1'b1, p, lat, busy, dones, re);
    checks++;
    if (p !== 16'd12 || dones != 1 || lat != W || busy != W + 1) begin
      errors++;
      $display("FAIL hold_start: prod=%0d dones=%0d lat=%0d busy=%0d required 12/1/%0d/%0d",
               p, dones, lat, busy, W, W + 1);
    end
    checks++;
    if (re !== 1'b1) begin
      errors++;
      $display("FAIL hold_start_idle: ready=%b required 1", re);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: ready=%b required 0", bus.ready);
    end
    wait_idle();
    checks++;
    if (bus.prod !== model(9, 9, 9)) begin
      errors++;
      $display("FAIL b2b_prod: got %h required %h", bus.prod, model(9, 9, 9));
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd200;
    bus.b = 8'd100;
    bus.c = 8'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.prod !== 16'h0 || bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: prod=%h ready=%b done=%b required 0000/1/0",
               bus.prod, bus.ready, bus.done_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done_tick) seen++;
    end
    checks++;
    if (seen != 0 || bus.prod !== 16'h0) begin
      errors++;
      $display("FAIL abort_nodone: dones=%0d prod=%h required 0/0000", seen, bus.prod);
    end
    check_op("after_abort", 8'd2, 8'd3, 8'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_divider_roundtrip();
    test_random();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
